// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU      = 1'b0;
  localparam logic PORT_DBG      = 1'b1;
  localparam int   DEFAULT_DEPTH = 128;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port not granted last wins.
// Purely combinational; grant is one-hot or zero.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (lastGrant == PORT_DBG) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates cpu/dbg accesses onto one data memory: Grant one cycle after the request edge, ReadValid the cycle after.
// No backpressure on responses; requests are only sampled in IDLE, so throughput is one access per 3 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [DATA_W-1:0] cpuWriteData,
  output logic              cpuGrant,
  output logic              cpuReadValid,
  output logic [DATA_W-1:0] cpuReadData,
  output logic              cpuError,
  input  logic              dbgReq,
  input  logic              dbgWrite,
  input  logic [ADDR_W-1:0] dbgAddress,
  input  logic [DATA_W-1:0] dbgWriteData,
  output logic              dbgGrant,
  output logic              dbgReadValid,
  output logic [DATA_W-1:0] dbgReadData,
  output logic              dbgError,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy
);

  state_t            state;
  logic              lastGrant;
  logic              winner;
  logic              latWrite;
  logic              latErr;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic [DATA_W-1:0] capData;

  logic [1:0]        grantVec;
  logic              sel;
  logic              selWrite;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selErr;

  rr_arb2 uArb (
    .req       ({dbgReq, cpuReq}),
    .lastGrant (lastGrant),
    .grant     (grantVec)
  );

  assign sel      = grantVec[PORT_DBG];
  assign selWrite = sel ? dbgWrite     : cpuWrite;
  assign selAddr  = sel ? dbgAddress   : cpuAddress;
  assign selData  = sel ? dbgWriteData : cpuWriteData;
  // Only 8-byte aligned addresses inside the memory are serviced.
  assign selErr   = (selAddr[2:0] != 3'b000) || (selAddr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lastGrant <= PORT_DBG;
      winner    <= PORT_CPU;
      latWrite  <= 1'b0;
      latErr    <= 1'b0;
      latAddr   <= '0;
      latData   <= '0;
      capData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grantVec) begin
            winner    <= sel;
            lastGrant <= sel;
            latWrite  <= selWrite;
            latAddr   <= selAddr;
            latData   <= selData;
            latErr    <= selErr;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          capData <= (latWrite || latErr) ? '0 : memReadData;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All strobes decode from registers so no Req reaches an output combinationally.
  assign busy         = (state != IDLE);
  assign memAddress   = latAddr;
  assign memWriteData = latData;
  assign memRead      = (state == ACCESS) && !latWrite && !latErr;
  assign memWrite     = (state == ACCESS) &&  latWrite && !latErr;

  assign cpuGrant     = (state == ACCESS) && (winner == PORT_CPU);
  assign dbgGrant     = (state == ACCESS) && (winner == PORT_DBG);
  assign cpuReadValid = (state == RESP)   && (winner == PORT_CPU);
  assign dbgReadValid = (state == RESP)   && (winner == PORT_DBG);
  assign cpuError     = cpuReadValid && latErr;
  assign dbgError     = dbgReadValid && latErr;
  assign cpuReadData  = cpuReadValid ? capData : '0;
  assign dbgReadData  = dbgReadValid ? capData : '0;

endmodule
